// File: rtl/wd_pkg.sv
// Shared types and widths for the watchdog-priority APB arbiter.
// Holds the FSM state encoding and the APB bus widths.
package wd_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    GAP    = 2'd3
  } state_e;

  // Index of the winner encoded in a 2-bit one-hot grant.
  function automatic logic grant_idx(input logic [1:0] grant);
    return grant[1];
  endfunction

endpackage

// File: rtl/wd_rr_arb.sv
// Two-way round-robin grant with a watchdog override for requester 0.
// Purely combinational; the caller owns the last_grant pointer.
module wd_rr_arb (
  input  logic [1:0] valid,
  input  logic       wd_intr,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (wd_intr && valid[0]) begin
      grant = 2'b01;
    end else if (valid == 2'b11) begin
      // On contention, favour whoever did not win last time.
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/wd_apb_arb.sv
// Two-requester APB master with round-robin arbitration, watchdog priority
// and a configurable idle gap between transfers.
module wd_apb_arb
  import wd_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  input  logic              wd_intr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  output logic              busy,
  output state_e            state_dbg
);

  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  // Handshake: a request transfers on a rising pclk where reqN_valid and
  // reqN_ready are both high; ready is only offered in IDLE, to one winner.
  state_e     state;
  state_e     state_nxt;
  logic [3:0] gap_cnt;
  logic [1:0] grant;
  logic [1:0] ready_vec;
  logic       accept;
  logic       last_grant;
  logic       cur_idx;
  logic       win_idx;

  wd_rr_arb u_arb (
    .valid      ({req1_valid, req0_valid}),
    .wd_intr    (wd_intr),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign ready_vec  = (state == IDLE && preset_n) ? grant : 2'b00;
  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];
  assign accept     = |ready_vec;
  assign win_idx    = grant_idx(grant);
  assign busy       = (state != IDLE);
  assign state_dbg  = state;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:     if (gap_cnt == 4'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      gap_cnt <= 4'd0;
    end else if (state == ACCESS) begin
      gap_cnt <= GAP_LOAD;
    end else if (state == GAP && gap_cnt != 4'd0) begin
      gap_cnt <= gap_cnt - 4'd1;
    end
  end

  // APB outputs, response pulses and the round-robin pointer.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
      cur_idx    <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            psel       <= 1'b1;
            pwrite     <= win_idx ? req1_write : req0_write;
            paddr      <= win_idx ? req1_addr  : req0_addr;
            pwdata     <= win_idx ? req1_wdata : req0_wdata;
            cur_idx    <= win_idx;
            last_grant <= win_idx;
          end
        end
        SETUP: begin
          penable <= 1'b1;
        end
        ACCESS: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          if (cur_idx) begin
            rsp1_valid <= 1'b1;
            if (!pwrite) rsp1_rdata <= prdata;
          end else begin
            rsp0_valid <= 1'b1;
            if (!pwrite) rsp0_rdata <= prdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wd_apb_arb.sv
// Bench for wd_apb_arb: two instances (GAP_CYCLES=2 and 0) checked every
// cycle against a timeline model plus a response-order scoreboard.
module tb_wd_apb_arb;

  logic       pclk;
  logic       preset_n;
  logic       rv   [2][2];
  logic       rw   [2][2];
  logic [7:0] ra   [2][2];
  logic [7:0] rd   [2][2];
  logic       rdy  [2][2];
  logic       rspv [2][2];
  logic [7:0] rspd [2][2];
  logic       wdi  [2];
  logic [7:0] prd  [2];
  logic       psel [2];
  logic       pen  [2];
  logic       pwr  [2];
  logic [7:0] pad  [2];
  logic [7:0] pwd  [2];
  logic       bsy  [2];
  wd_pkg::state_e st [2];

  int tests_run;
  int tests_failed;
  int cyc;

  // Model: age counts clock edges since the last acceptance.
  int         age  [2];
  logic       last [2];
  int         cur  [2];
  logic       mw   [2];
  logic [7:0] ma   [2];
  logic [7:0] md   [2];
  logic [7:0] mrd  [2][2];
  int         acc_n [2];
  int         acc_cyc [2];
  int         prev_acc_cyc [2];
  logic [0:0] exp_q0 [$];
  logic [0:0] exp_q1 [$];

  wd_apb_arb #(.GAP_CYCLES(2)) dut_g2 (
    .pclk(pclk), .preset_n(preset_n),
    .req0_valid(rv[0][0]), .req0_ready(rdy[0][0]), .req0_write(rw[0][0]),
    .req0_addr(ra[0][0]), .req0_wdata(rd[0][0]),
    .req1_valid(rv[0][1]), .req1_ready(rdy[0][1]), .req1_write(rw[0][1]),
    .req1_addr(ra[0][1]), .req1_wdata(rd[0][1]),
    .rsp0_valid(rspv[0][0]), .rsp0_rdata(rspd[0][0]),
    .rsp1_valid(rspv[0][1]), .rsp1_rdata(rspd[0][1]),
    .wd_intr(wdi[0]), .psel(psel[0]), .penable(pen[0]), .pwrite(pwr[0]),
    .paddr(pad[0]), .pwdata(pwd[0]), .prdata(prd[0]), .busy(bsy[0]),
    .state_dbg(st[0])
  );

  wd_apb_arb #(.GAP_CYCLES(0)) dut_g0 (
    .pclk(pclk), .preset_n(preset_n),
    .req0_valid(rv[1][0]), .req0_ready(rdy[1][0]), .req0_write(rw[1][0]),
    .req0_addr(ra[1][0]), .req0_wdata(rd[1][0]),
    .req1_valid(rv[1][1]), .req1_ready(rdy[1][1]), .req1_write(rw[1][1]),
    .req1_addr(ra[1][1]), .req1_wdata(rd[1][1]),
    .rsp0_valid(rspv[1][0]), .rsp0_rdata(rspd[1][0]),
    .rsp1_valid(rspv[1][1]), .rsp1_rdata(rspd[1][1]),
    .wd_intr(wdi[1]), .psel(psel[1]), .penable(pen[1]), .pwrite(pwr[1]),
    .paddr(pad[1]), .pwdata(pwd[1]), .prdata(prd[1]), .busy(bsy[1]),
    .state_dbg(st[1])
  );

  // ---------------- clock / reset ----------------
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- checking ----------------
  function automatic logic [31:0] b(input logic x);
    return {31'b0, x};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int gap_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  // Winner of arbitration this cycle, or -1 when nobody may be accepted.
  function automatic int win(input int k);
    if (!preset_n || age[k] < 3 + gap_of(k)) return -1;
    if (wdi[k] && rv[k][0]) return 0;
    if (rv[k][0] && rv[k][1]) return last[k] ? 0 : 1;
    if (rv[k][0]) return 0;
    if (rv[k][1]) return 1;
    return -1;
  endfunction

  task automatic model_reset(input int k);
    age[k] = 100; last[k] = 1'b1; cur[k] = 0;
    mw[k] = 1'b0; ma[k] = 8'h00; md[k] = 8'h00;
    mrd[k][0] = 8'h00; mrd[k][1] = 8'h00;
    acc_n[k] = -1; acc_cyc[k] = -100; prev_acc_cyc[k] = -100;
    if (k == 0) exp_q0.delete(); else exp_q1.delete();
  endtask

  task automatic model_edge(input int k);
    int w;
    if (!preset_n) begin
      model_reset(k);
      return;
    end
    w = win(k);
    acc_n[k] = w;
    if (age[k] == 2 && !mw[k]) mrd[k][cur[k]] = prd[k];
    if (w >= 0) begin
      prev_acc_cyc[k] = acc_cyc[k];
      acc_cyc[k] = cyc;
      age[k] = 1; cur[k] = w; last[k] = w[0];
      mw[k] = rw[k][w]; ma[k] = ra[k][w]; md[k] = rd[k][w];
      if (k == 0) exp_q0.push_back(w[0]); else exp_q1.push_back(w[0]);
    end else if (age[k] < 100) begin
      age[k]++;
    end
  endtask

  task automatic check_inst(input int k);
    int w;
    logic [0:0] e;
    w = win(k);
    check($sformatf("ready0_i%0d", k), b(rdy[k][0]), b(w == 0));
    check($sformatf("ready1_i%0d", k), b(rdy[k][1]), b(w == 1));
    check($sformatf("psel_i%0d", k), b(psel[k]), b(age[k] == 1 || age[k] == 2));
    check($sformatf("penable_i%0d", k), b(pen[k]), b(age[k] == 2));
    check($sformatf("busy_i%0d", k), b(bsy[k]), b(age[k] < 3 + gap_of(k)));
    check($sformatf("state_idle_i%0d", k), b(st[k] == wd_pkg::IDLE), b(age[k] >= 3 + gap_of(k)));
    check($sformatf("pwrite_i%0d", k), b(pwr[k]), b(mw[k]));
    check($sformatf("paddr_i%0d", k), 32'(pad[k]), 32'(ma[k]));
    check($sformatf("pwdata_i%0d", k), 32'(pwd[k]), 32'(md[k]));
    for (int n = 0; n < 2; n++) begin
      check($sformatf("rsp%0d_valid_i%0d", n, k), b(rspv[k][n]), b(age[k] == 3 && cur[k] == n));
      check($sformatf("rsp%0d_rdata_i%0d", n, k), 32'(rspd[k][n]), 32'(mrd[k][n]));
      if (rspv[k][n] === 1'b1) begin
        if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
          check($sformatf("sb_unexpected_rsp_i%0d", k), 32'(1), 32'(0));
        end else begin
          e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          check($sformatf("sb_rsp_idx_i%0d", k), 32'(n), 32'(e));
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    #1;
    if (!preset_n) begin
      model_reset(0);
      model_reset(1);
    end
    check_inst(0);
    check_inst(1);
    model_edge(0);
    model_edge(1);
    cyc++;
    @(negedge pclk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic req(input int k, input int n, input logic w, input logic [7:0] a, input logic [7:0] d);
    rv[k][n] = 1'b1; rw[k][n] = w; ra[k][n] = a; rd[k][n] = d;
  endtask

  task automatic next_acc(input int k, input int budget, output int n);
    n = -1;
    for (int i = 0; i < budget && n < 0; i++) begin
      step();
      if (acc_n[k] >= 0) n = acc_n[k];
    end
    if (n < 0) check($sformatf("accept_timeout_i%0d", k), 32'(budget), 32'(0));
  endtask

  task automatic rand_drive();
    for (int k = 0; k < 2; k++) begin
      if ($urandom_range(0, 9) == 0) wdi[k] = ~wdi[k];
      prd[k] = 8'($urandom);
      for (int n = 0; n < 2; n++) begin
        if (rv[k][n]) begin
          if (acc_n[k] == n || $urandom_range(0, 19) == 0) rv[k][n] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req(k, n, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        end
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int prev_n;
    tests_run = 0; tests_failed = 0; cyc = 0;
    preset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wdi[k] = 1'b0; prd[k] = 8'h00;
      for (int j = 0; j < 2; j++) begin
        rv[k][j] = 1'b0; rw[k][j] = 1'b0; ra[k][j] = 8'h00; rd[k][j] = 8'h00;
      end
      model_reset(k);
    end
    @(negedge pclk);
    run(3);
    preset_n = 1'b1;

    // Single write from req0 on the GAP=2 instance.
    req(0, 0, 1'b1, 8'h04, 8'h5A);
    next_acc(0, 4, n);
    rv[0][0] = 1'b0;
    check("wr_grant", 32'(n), 32'(0));
    #1;
    check("wr_setup_psel", b(psel[0]), b(1'b1));
    check("wr_setup_penable", b(pen[0]), b(1'b0));
    step();
    #1;
    check("wr_access_penable", b(pen[0]), b(1'b1));
    check("wr_access_paddr", 32'(pad[0]), 32'h04);
    check("wr_access_pwdata", 32'(pwd[0]), 32'h5A);
    check("wr_access_pwrite", b(pwr[0]), b(1'b1));
    step();
    #1;
    check("wr_rsp0_valid", b(rspv[0][0]), b(1'b1));
    run(4);

    // Read from req1 with a fixed prdata.
    prd[0] = 8'hC3;
    req(0, 1, 1'b0, 8'h08, 8'h00);
    next_acc(0, 4, n);
    rv[0][1] = 1'b0;
    check("rd_grant", 32'(n), 32'(1));
    run(2);
    #1;
    check("rd_rsp1_valid", b(rspv[0][1]), b(1'b1));
    check("rd_rsp1_rdata", 32'(rspd[0][1]), 32'hC3);
    check("rd_rsp0_quiet", b(rspv[0][0]), b(1'b0));
    run(4);

    // Continuous contention: grants alternate, 5 cycles apart.
    req(0, 0, 1'b1, 8'h10, 8'h11);
    req(0, 1, 1'b0, 8'h20, 8'h00);
    prev_n = -1;
    for (int i = 0; i < 6; i++) begin
      next_acc(0, 12, n);
      if (i > 0) begin
        check("rr_spacing", 32'(acc_cyc[0] - prev_acc_cyc[0]), 32'(5));
        check("rr_alternate", 32'(n), 32'(1 - prev_n));
      end
      prev_n = n;
      if (n >= 0) req(0, n, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    end

    // Watchdog priority keeps req0 winning until it drops.
    wdi[0] = 1'b1;
    run(5);
    for (int i = 0; i < 3; i++) begin
      next_acc(0, 12, n);
      check("prio_req0_wins", 32'(n), 32'(0));
    end
    wdi[0] = 1'b0;
    next_acc(0, 12, n);
    check("prio_release_req1", 32'(n), 32'(1));
    rv[0][0] = 1'b0; rv[0][1] = 1'b0;
    run(6);

    // GAP_CYCLES=0: back-to-back req0 every 3 cycles.
    req(1, 0, 1'b1, 8'h30, 8'h31);
    for (int i = 0; i < 4; i++) begin
      next_acc(1, 8, n);
      check("gap0_grant", 32'(n), 32'(0));
      if (i > 0) check("gap0_spacing", 32'(acc_cyc[1] - prev_acc_cyc[1]), 32'(3));
    end
    rv[1][0] = 1'b0;
    run(4);

    // Reset during ACCESS aborts the transfer and restores the pointer.
    req(0, 0, 1'b0, 8'h40, 8'h00);
    next_acc(0, 4, n);
    rv[0][0] = 1'b0;
    step();
    preset_n = 1'b0;
    #1;
    check("rst_psel", b(psel[0]), b(1'b0));
    check("rst_penable", b(pen[0]), b(1'b0));
    check("rst_busy", b(bsy[0]), b(1'b0));
    run(2);
    preset_n = 1'b1;
    run(3);
    req(0, 0, 1'b1, 8'h50, 8'h51);
    req(0, 1, 1'b1, 8'h60, 8'h61);
    next_acc(0, 4, n);
    check("rst_first_grant", 32'(n), 32'(0));
    rv[0][0] = 1'b0; rv[0][1] = 1'b0;
    run(8);

    // Random traffic on both instances.
    for (int i = 0; i < 800; i++) begin
      rand_drive();
      step();
    end

    for (int k = 0; k < 2; k++) begin
      wdi[k] = 1'b0;
      rv[k][0] = 1'b0;
      rv[k][1] = 1'b0;
    end
    run(10);
    check("sb_drain_i0", 32'(exp_q0.size()), 32'(0));
    check("sb_drain_i1", 32'(exp_q1.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
